step_move_planner: RTL and testbench

//   Motion-profile stage directly upstream of the step pulse generator. Accepts one move

---
 rtl/step_move_planner.sv | 191 +++++++++++++++++++
 tb/tb_step_move_planner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/step_move_planner.sv
// Step move planner: turns one move command into a trapezoidal or triangular
// period ramp for the downstream step pulse generator, counting its step ticks
// and reporting completion or abort.
module step_move_planner #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned ACC_STEP = 16,
  parameter int unsigned SETTLE   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_start_period,
  input  logic [WIDTH-1:0] cmd_min_period,
  input  logic             abort,
  input  logic             step_tick,
  output logic             drv_enable,
  output logic             drv_dir,
  output logic [WIDTH-1:0] drv_period,
  output logic [CNT_W-1:0] steps_left,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [2:0] {
    StIdle,
    StDirSetup,
    StAccel,
    StCruise,
    StDecel,
    StDone
  } state_e;

  localparam logic [WIDTH:0]   AccStepW   = (WIDTH + 1)'(ACC_STEP);
  localparam logic [WIDTH-1:0] AccStep    = WIDTH'(ACC_STEP);
  localparam logic [7:0]       SettleLast = 8'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [CNT_W-1:0] n_acc_q, n_acc_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic             dir_q, dir_d;
  logic             aborted_q, aborted_d;
  logic [7:0]       settle_q, settle_d;

  logic             moving;
  logic [CNT_W-1:0] steps_dec;
  logic [CNT_W-1:0] n_inc;
  logic [WIDTH-1:0] period_dn;
  logic [WIDTH:0]   period_up_w;
  logic [WIDTH-1:0] period_up;
  logic [WIDTH-1:0] start_clamped;

  // Ramp arithmetic: compare before subtracting, add at WIDTH+1 bits so neither wraps.
  always_comb begin
    steps_dec     = steps_q - CNT_W'(1);
    n_inc         = n_acc_q + CNT_W'(1);
    period_dn     = ({1'b0, period_q} >= ({1'b0, min_q} + AccStepW)) ? (period_q - AccStep)
                                                                      : min_q;
    period_up_w   = {1'b0, period_q} + AccStepW;
    period_up     = (period_up_w >= {1'b0, start_q}) ? start_q : period_up_w[WIDTH-1:0];
    start_clamped = (cmd_start_period < cmd_min_period) ? cmd_min_period : cmd_start_period;
    moving        = (state_q == StAccel) || (state_q == StCruise) || (state_q == StDecel);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    steps_d   = steps_q;
    n_acc_d   = n_acc_q;
    period_d  = period_q;
    start_d   = start_q;
    min_d     = min_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    settle_d  = settle_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          steps_d   = cmd_steps;
          n_acc_d   = '0;
          dir_d     = cmd_dir;
          start_d   = start_clamped;
          min_d     = cmd_min_period;
          // Clamped start keeps the period at or above min for the whole move.
          period_d  = start_clamped;
          aborted_d = 1'b0;
          settle_d  = '0;
          state_d   = (cmd_steps == '0) ? StDone : StDirSetup;
        end
      end
      StDirSetup: begin
        if (settle_q == SettleLast) begin
          state_d = StAccel;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      StAccel: begin
        if (step_tick) begin
          steps_d  = steps_dec;
          n_acc_d  = n_inc;
          period_d = period_dn;
          if (steps_dec == '0) begin
            state_d = StDone;
          end else if (steps_dec <= n_inc) begin
            state_d = StDecel;
          end else if (period_dn == min_q) begin
            state_d = StCruise;
          end
        end
      end
      StCruise: begin
        if (step_tick) begin
          steps_d = steps_dec;
          if (steps_dec == '0) begin
            state_d = StDone;
          end else if (steps_dec <= n_acc_q) begin
            state_d = StDecel;
          end
        end
      end
      StDecel: begin
        if (step_tick) begin
          steps_d  = steps_dec;
          period_d = period_up;
          if (steps_dec == '0) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides any transition; a same-cycle tick has already been counted above.
    if (abort && (moving || (state_q == StDirSetup))) begin
      state_d   = StDone;
      aborted_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      steps_q   <= '0;
      n_acc_q   <= '0;
      period_q  <= '0;
      start_q   <= '0;
      min_q     <= '0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      steps_q   <= steps_d;
      n_acc_q   <= n_acc_d;
      period_q  <= period_d;
      start_q   <= start_d;
      min_q     <= min_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
      settle_q  <= settle_d;
    end
  end

  // Output decode.
  always_comb begin
    cmd_ready  = (state_q == StIdle) && !rst;
    busy       = (state_q != StIdle);
    drv_enable = moving;
    done       = (state_q == StDone);
    aborted    = (state_q == StDone) && aborted_q;
    drv_dir    = dir_q;
    drv_period = period_q;
    steps_left = steps_q;
  end

endmodule

// File: tb/tb_step_move_planner.sv
// Directed bench for step_move_planner: trapezoid, triangle, zero-step move,
// abort, start-period clamp, handshake hold-off and mid-move reset.
module tb_step_move_planner;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_steps;
  logic        cmd_dir;
  logic [15:0] cmd_start_period;
  logic [15:0] cmd_min_period;
  logic        abort;
  logic        step_tick;
  logic        drv_enable;
  logic        drv_dir;
  logic [15:0] drv_period;
  logic [23:0] steps_left;
  logic        busy;
  logic        done;
  logic        aborted;

  int total;
  int bad;

  step_move_planner dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_steps        (cmd_steps),
    .cmd_dir          (cmd_dir),
    .cmd_start_period (cmd_start_period),
    .cmd_min_period   (cmd_min_period),
    .abort            (abort),
    .step_tick        (step_tick),
    .drv_enable       (drv_enable),
    .drv_dir          (drv_dir),
    .drv_period       (drv_period),
    .steps_left       (steps_left),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick();
    step_tick = 1'b1;
    cyc();
    step_tick = 1'b0;
  endtask

  task automatic send(input logic [23:0] steps, input logic dir, input logic [15:0] start,
                      input logic [15:0] minp);
    cmd_valid        = 1'b1;
    cmd_steps        = steps;
    cmd_dir          = dir;
    cmd_start_period = start;
    cmd_min_period   = minp;
    cyc();
    cmd_valid = 1'b0;
  endtask

  logic [15:0] t1_per [10];
  logic [15:0] t2_per [4];

  initial begin
    total = 0;
    bad   = 0;
    t1_per = '{16'd84, 16'd68, 16'd60, 16'd60, 16'd60, 16'd60, 16'd60, 16'd76, 16'd92, 16'd100};
    t2_per = '{16'd84, 16'd68, 16'd84, 16'd100};
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_steps = '0;
    cmd_dir = 1'b0;
    cmd_start_period = '0;
    cmd_min_period = '0;
    abort = 1'b0;
    step_tick = 1'b0;

    // Reset state
    cyc();
    cyc();
    check("rst_enable", 32'(drv_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready_in_rst", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    cyc();
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_period", 32'(drv_period), 32'd0);
    check("rst_steps", 32'(steps_left), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // T1 trapezoid
    send(24'd10, 1'b1, 16'd100, 16'd60);
    check("t1_dir", 32'(drv_dir), 32'd1);
    check("t1_period0", 32'(drv_period), 32'd100);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready_busy", 32'(cmd_ready), 32'd0);
    check("t1_settle_en0", 32'(drv_enable), 32'd0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      check("t1_settle_en", 32'(drv_enable), 32'd0);
    end
    cyc();
    check("t1_enable", 32'(drv_enable), 32'd1);
    for (int i = 0; i < 10; i++) begin
      pulse_tick();
      check("t1_period", 32'(drv_period), 32'(t1_per[i]));
      check("t1_steps", 32'(steps_left), 32'(9 - i));
    end
    check("t1_done", 32'(done), 32'd1);
    check("t1_aborted", 32'(aborted), 32'd0);
    check("t1_done_en", 32'(drv_enable), 32'd0);
    cyc();
    check("t1_done_clr", 32'(done), 32'd0);
    check("t1_ready_back", 32'(cmd_ready), 32'd1);

    // T2 triangle
    send(24'd4, 1'b1, 16'd100, 16'd60);
    repeat (4) cyc();
    check("t2_enable", 32'(drv_enable), 32'd1);
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      check("t2_period", 32'(drv_period), 32'(t2_per[i]));
    end
    check("t2_done", 32'(done), 32'd1);
    cyc();

    // T3 zero steps
    send(24'd0, 1'b0, 16'd100, 16'd60);
    check("t3_done", 32'(done), 32'd1);
    check("t3_enable", 32'(drv_enable), 32'd0);
    check("t3_ready_low", 32'(cmd_ready), 32'd0);
    cyc();
    check("t3_ready_back", 32'(cmd_ready), 32'd1);
    check("t3_done_clr", 32'(done), 32'd0);

    // T4 abort in cruise after tick 5
    send(24'd10, 1'b1, 16'd100, 16'd60);
    repeat (4) cyc();
    repeat (5) pulse_tick();
    check("t4_steps_pre", 32'(steps_left), 32'd5);
    check("t4_cruise_period", 32'(drv_period), 32'd60);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t4_enable", 32'(drv_enable), 32'd0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_aborted", 32'(aborted), 32'd1);
    check("t4_steps", 32'(steps_left), 32'd5);
    pulse_tick();
    check("t4_tick_ignored_done", 32'(steps_left), 32'd5);
    check("t4_idle", 32'(busy), 32'd0);
    pulse_tick();
    check("t4_tick_ignored_idle", 32'(steps_left), 32'd5);

    // T5 clamp, handshake hold-off and mid-move reset
    send(24'd3, 1'b0, 16'd50, 16'd60);
    cmd_valid = 1'b1;
    cmd_steps = 24'd2;
    check("t5_dir", 32'(drv_dir), 32'd0);
    check("t5_clamp0", 32'(drv_period), 32'd60);
    repeat (4) cyc();
    check("t5_enable", 32'(drv_enable), 32'd1);
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      check("t5_clamp", 32'(drv_period), 32'd60);
    end
    check("t5_done", 32'(done), 32'd1);
    cyc();
    check("t5_idle_ready", 32'(cmd_ready), 32'd1);
    check("t5_not_taken_early", 32'(steps_left), 32'd0);
    cyc();
    cmd_valid = 1'b0;
    check("t5_taken", 32'(steps_left), 32'd2);
    check("t5_taken_busy", 32'(busy), 32'd1);
    repeat (4) cyc();
    check("t5_accel_en", 32'(drv_enable), 32'd1);
    rst = 1'b1;
    cyc();
    check("t5_rst_enable", 32'(drv_enable), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_period", 32'(drv_period), 32'd0);
    check("t5_rst_steps", 32'(steps_left), 32'd0);
    rst = 1'b0;
    cyc();
    check("t5_post_rst_done", 32'(done), 32'd0);
    check("t5_post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
